mem_ctrl: RTL and testbench

Byte-sequencing controller and two-port arbiter for the 128 KB on-board byte-wide synchronous RAM. It sits between the CPU core and the RAM. It serves 32-bit instruction fetches and 1/2/4-byte load/store requests. Each request is split into consecutive byte accesses, assembled little-endian, and returned with a one-cycle done pulse.

---
 rtl/mem_ctrl_pkg.sv | 33 +++
 rtl/mem_ctrl_if.sv | 50 +++++
 rtl/mem_ctrl_rr_arb2.sv | 39 +++
 rtl/mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and constants for the byte-sequencing RAM controller:
//   - state_e   : controller FSM states
//   - LEN_*     : load/store length encodings as seen on lsu_len_in
//   - PORT_*    : requester ids used by the arbiter and the controller
//   - len_to_bytes() : decode a length encoding into a byte count
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b11;

  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_LSU = 1'b1;

  // The unused encoding 2'b10 decodes as a full word.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
// Bundles the CPU-side fetch/LSU handshakes and the byte-wide RAM bus.
//   slave  : the controller (consumes requests and RAM read data)
//   master : the CPU core plus RAM (drives requests and RAM read data)
// Fetch : ifetch_req_in/addr_in/clr_in -> ifetch_done_out/data_out
// LSU   : lsu_req_in/we_in/len_in/addr_in/wdata_in -> lsu_done_out/rdata_out
// RAM   : ram_en_out/r_nw_out/a_out/d_out -> ram_d_in
// -----------------------------------------------------------------------------
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  ifetch_req_in;
  logic [31:0]           ifetch_addr_in;
  logic                  ifetch_clr_in;
  logic                  ifetch_done_out;
  logic [31:0]           ifetch_data_out;

  logic                  lsu_req_in;
  logic                  lsu_we_in;
  logic [1:0]            lsu_len_in;
  logic [31:0]           lsu_addr_in;
  logic [31:0]           lsu_wdata_in;
  logic                  lsu_done_out;
  logic [31:0]           lsu_rdata_out;

  logic                  ram_en_out;
  logic                  ram_r_nw_out;
  logic [ADDR_WIDTH-1:0] ram_a_out;
  logic [7:0]            ram_d_out;
  logic [7:0]            ram_d_in;

  modport slave (
    input  ifetch_req_in, ifetch_addr_in, ifetch_clr_in,
    output ifetch_done_out, ifetch_data_out,
    input  lsu_req_in, lsu_we_in, lsu_len_in, lsu_addr_in, lsu_wdata_in,
    output lsu_done_out, lsu_rdata_out,
    output ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out,
    input  ram_d_in
  );

  modport master (
    output ifetch_req_in, ifetch_addr_in, ifetch_clr_in,
    input  ifetch_done_out, ifetch_data_out,
    output lsu_req_in, lsu_we_in, lsu_len_in, lsu_addr_in, lsu_wdata_in,
    input  lsu_done_out, lsu_rdata_out,
    input  ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out,
    output ram_d_in
  );
endinterface

// File: rtl/mem_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter with a one-bit pointer naming the
// favoured port. The pointer moves to the other port after every grant.
//   clk_in, rst_n_in : clock, async active-low reset (pointer favours LSU)
//   i_en             : arbitrate this cycle (controller idle)
//   i_req_if/lsu     : qualified requests
//   o_gnt            : a grant is issued this cycle
//   o_gnt_port       : granted port id (PORT_IF / PORT_LSU)
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic i_en,
  input  logic i_req_if,
  input  logic i_req_lsu,
  output logic o_gnt,
  output logic o_gnt_port
);

  logic r_ptr;

  // NOTE: every output gets a default before the ifs, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_gnt      = i_en & (i_req_if | i_req_lsu);
    o_gnt_port = PORT_IF;
    if (i_req_if & i_req_lsu) o_gnt_port = r_ptr;
    else if (i_req_lsu)       o_gnt_port = PORT_LSU;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of process order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)  r_ptr <= PORT_LSU;
    else if (o_gnt) r_ptr <= ~o_gnt_port;
  end

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Splits 32-bit instruction fetches and 1/2/4-byte LSU requests into
// consecutive byte accesses on a byte-wide synchronous RAM, assembles read
// bytes little-endian and returns them with a one-cycle done pulse.
//   clk_in   : system clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : mem_ctrl_if.slave (fetch port, LSU port, RAM bus)
// All RAM-side and CPU-side outputs are registered.
// -----------------------------------------------------------------------------
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  mem_ctrl_if.slave   bus
);

  state_e                r_state, w_state_nxt;
  logic                  r_port;
  logic [2:0]            r_len;      // bytes in the transaction (1, 2 or 4)
  logic [2:0]            r_cnt;      // READ: cycle-1 of the transfer; WRITE: byte index
  logic [31:0]           r_wdata;
  logic [31:0]           r_buf;      // lanes captured so far
  logic                  r_ram_en, r_ram_r_nw;
  logic [ADDR_WIDTH-1:0] r_ram_a;
  logic [7:0]            r_ram_d;
  logic                  r_if_done, r_lsu_done;
  logic [31:0]           r_if_data, r_lsu_rdata;

  logic                  w_req_if, w_req_lsu, w_gnt, w_gnt_port, w_gnt_write;
  logic                  w_abort, w_rd_last, w_wr_last;
  logic [1:0]            w_lane, w_next_lane;
  logic [31:0]           w_merged;
  logic                  w_unused_addr_hi;

  // A port is not re-granted in its own done cycle; a flushing fetch is never granted.
  assign w_req_if  = bus.ifetch_req_in & ~bus.ifetch_clr_in & ~r_if_done;
  assign w_req_lsu = bus.lsu_req_in & ~r_lsu_done;

  rr_arb2 u_arb (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .i_en       (r_state == IDLE),
    .i_req_if   (w_req_if),
    .i_req_lsu  (w_req_lsu),
    .o_gnt      (w_gnt),
    .o_gnt_port (w_gnt_port)
  );

  assign w_gnt_write = (w_gnt_port == PORT_LSU) & bus.lsu_we_in;
  assign w_abort     = (r_state == READ) & (r_port == PORT_IF) & bus.ifetch_clr_in;
  // Reads need one extra cycle because RAM data lags its address by one cycle.
  assign w_rd_last   = (r_cnt == r_len);
  assign w_wr_last   = (r_cnt == r_len - 3'd1);
  assign w_lane      = r_cnt[1:0] - 2'd1;   // lane arriving on ram_d_in now
  assign w_next_lane = r_cnt[1:0] + 2'd1;
  assign w_unused_addr_hi = ^{bus.ifetch_addr_in[31:ADDR_WIDTH], bus.lsu_addr_in[31:ADDR_WIDTH]};

  always_comb begin
    w_merged = r_buf;
    w_merged[{w_lane, 3'b000} +: 8] = bus.ram_d_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_gnt) w_state_nxt = w_gnt_write ? WRITE : READ;
      READ:    if (w_abort || w_rd_last) w_state_nxt = IDLE;
      WRITE:   if (w_wr_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_port      <= PORT_LSU;
      r_len       <= 3'd0;
      r_cnt       <= 3'd0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_ram_en    <= 1'b0;
      r_ram_r_nw  <= 1'b1;
      r_ram_a     <= '0;
      r_ram_d     <= '0;
      r_if_done   <= 1'b0;
      r_lsu_done  <= 1'b0;
      r_if_data   <= '0;
      r_lsu_rdata <= '0;
    end else begin
      r_if_done  <= 1'b0;
      r_lsu_done <= 1'b0;
      unique case (r_state)
        IDLE: if (w_gnt) begin
          r_port   <= w_gnt_port;
          r_cnt    <= 3'd0;
          r_buf    <= '0;
          r_ram_en <= 1'b1;
          r_wdata  <= bus.lsu_wdata_in;
          if (w_gnt_port == PORT_IF) begin
            r_len      <= 3'd4;
            r_ram_a    <= bus.ifetch_addr_in[ADDR_WIDTH-1:0];
            r_ram_r_nw <= 1'b1;
          end else begin
            r_len      <= len_to_bytes(bus.lsu_len_in);
            r_ram_a    <= bus.lsu_addr_in[ADDR_WIDTH-1:0];
            r_ram_r_nw <= ~bus.lsu_we_in;
            if (bus.lsu_we_in) r_ram_d <= bus.lsu_wdata_in[7:0];
          end
        end
        READ: begin
          if (w_abort) begin
            r_ram_en <= 1'b0;
          end else begin
            if (r_cnt != 3'd0) r_buf <= w_merged;
            if (w_rd_last) begin
              r_ram_en <= 1'b0;
              if (r_port == PORT_IF) begin
                r_if_done <= 1'b1;
                r_if_data <= w_merged;
              end else begin
                r_lsu_done  <= 1'b1;
                r_lsu_rdata <= w_merged;
              end
            end else begin
              r_cnt <= r_cnt + 3'd1;
              // Hold the final address for the extra capture cycle.
              if (r_cnt + 3'd1 < r_len) r_ram_a <= r_ram_a + ADDR_WIDTH'(1);
            end
          end
        end
        WRITE: begin
          if (w_wr_last) begin
            r_ram_en   <= 1'b0;
            r_ram_r_nw <= 1'b1;
            r_lsu_done <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 3'd1;
            r_ram_a <= r_ram_a + ADDR_WIDTH'(1);
            r_ram_d <= r_wdata[{w_next_lane, 3'b000} +: 8];
          end
        end
        default: r_ram_en <= 1'b0;
      endcase
    end
  end

  assign bus.ifetch_done_out = r_if_done;
  assign bus.ifetch_data_out = r_if_data;
  assign bus.lsu_done_out    = r_lsu_done;
  assign bus.lsu_rdata_out   = r_lsu_rdata;
  assign bus.ram_en_out      = r_ram_en;
  assign bus.ram_r_nw_out    = r_ram_r_nw;
  assign bus.ram_a_out       = r_ram_a;
  assign bus.ram_d_out       = r_ram_d;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Scoreboarded bench for mem_ctrl with a byte-wide synchronous RAM model.
// Expected read data comes from a shadow copy of RAM updated as stores are
// issued; cycle-level behaviour is checked against per-cycle output logs.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  localparam int LOGN = 4096;
  localparam int MEMN = 131072;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } lsu_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_WIDTH(17)) bus ();

  mem_ctrl #(.ADDR_WIDTH(17)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  // RAM model: registered read, output gated by the current enable.
  logic [7:0] mem    [MEMN];
  logic [7:0] shadow [MEMN];
  logic [7:0] ram_q = 8'h00;
  always @(posedge clk) begin
    if (bus.ram_en_out) begin
      if (!bus.ram_r_nw_out) mem[bus.ram_a_out] <= bus.ram_d_out;
      ram_q <= mem[bus.ram_a_out];
    end
  end
  assign bus.ram_d_in = bus.ram_en_out ? ram_q : 8'h00;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  logic [31:0] exp_last = '0;
  logic [31:0] sb_if [$];
  lsu_exp_t    sb_lsu [$];
  lsu_exp_t    m_e;
  logic [31:0] m_w;

  logic                 log_en  [LOGN];
  logic                 log_rnw [LOGN];
  logic [16:0]          log_a   [LOGN];
  logic [7:0]           log_d   [LOGN];
  logic                 log_ifd [LOGN];
  logic                 log_lsd [LOGN];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] len);
    if (len == 2'b00) return 1;
    if (len == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] sh_read(input logic [31:0] a, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = shadow[int'((a + 32'(k)) & 32'h1FFFF)];
    return r;
  endfunction

  function automatic int count_ifd(input int from, input int to);
    int s = 0;
    for (int i = from; i <= to; i++) s += int'(log_ifd[i]);
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle log and scoreboard pop, sampled mid-cycle.
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      log_en[cyc]  = bus.ram_en_out;
      log_rnw[cyc] = bus.ram_r_nw_out;
      log_a[cyc]   = bus.ram_a_out;
      log_d[cyc]   = bus.ram_d_out;
      log_ifd[cyc] = bus.ifetch_done_out;
      log_lsd[cyc] = bus.lsu_done_out;
    end
    if (bus.ifetch_done_out) begin
      if (sb_if.size() == 0) check("if_unexpected_done", 1, 0);
      else begin
        m_w = sb_if.pop_front();
        check("if_data", bus.ifetch_data_out, m_w);
      end
    end
    if (bus.lsu_done_out) begin
      if (sb_lsu.size() == 0) check("lsu_unexpected_done", 1, 0);
      else begin
        m_e = sb_lsu.pop_front();
        check(m_e.we ? "lsu_rdata_hold" : "lsu_rdata", bus.lsu_rdata_out, m_e.data);
      end
    end
  end

  task automatic idle_inputs();
    bus.ifetch_req_in  = 1'b0;
    bus.ifetch_addr_in = '0;
    bus.ifetch_clr_in  = 1'b0;
    bus.lsu_req_in     = 1'b0;
    bus.lsu_we_in      = 1'b0;
    bus.lsu_len_in     = 2'b00;
    bus.lsu_addr_in    = '0;
    bus.lsu_wdata_in   = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    sb_if.delete();
    sb_lsu.delete();
    exp_last = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_fetch(input logic [31:0] addr, output int t0);
    bit seen = 1'b0;
    sb_if.push_back(sh_read(addr, 4));
    bus.ifetch_addr_in = addr;
    bus.ifetch_req_in  = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = bus.ifetch_done_out;
    end
    check("if_timeout", 32'(seen), 1);
    @(posedge clk);
    #1 bus.ifetch_req_in = 1'b0;
  endtask

  task automatic do_lsu(input logic we, input logic [1:0] len, input logic [31:0] addr,
                        input logic [31:0] wdata, output int t0);
    bit seen = 1'b0;
    int n = nbytes(len);
    if (we) begin
      for (int k = 0; k < n; k++) shadow[int'((addr + 32'(k)) & 32'h1FFFF)] = wdata[8*k +: 8];
      sb_lsu.push_back('{we: 1'b1, data: exp_last});
    end else begin
      exp_last = sh_read(addr, n);
      sb_lsu.push_back('{we: 1'b0, data: exp_last});
    end
    bus.lsu_we_in    = we;
    bus.lsu_len_in   = len;
    bus.lsu_addr_in  = addr;
    bus.lsu_wdata_in = wdata;
    bus.lsu_req_in   = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = bus.lsu_done_out;
    end
    check("lsu_timeout", 32'(seen), 1);
    @(posedge clk);
    #1 bus.lsu_req_in = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    logic [31:0] addr_tab [6];
    addr_tab = '{32'h0000_0000, 32'h0000_0010, 32'h0001_FFFE, 32'h0001_FFFD,
                 32'hFFFE_0123, 32'h0000_0020};

    for (int i = 0; i < MEMN; i++) begin
      mem[i]    = 8'(i * 7 + 3);
      shadow[i] = 8'(i * 7 + 3);
    end
    mem[32'h100] = 8'h13; mem[32'h101] = 8'h00; mem[32'h102] = 8'h00; mem[32'h103] = 8'h93;
    shadow[32'h100] = 8'h13; shadow[32'h101] = 8'h00; shadow[32'h102] = 8'h00; shadow[32'h103] = 8'h93;

    // Reset state.
    do_reset();
    @(negedge clk);
    check("rst_en", bus.ram_en_out, 0);
    check("rst_rnw", bus.ram_r_nw_out, 1);
    check("rst_a", bus.ram_a_out, 0);
    check("rst_d", bus.ram_d_out, 0);
    check("rst_dones", {bus.ifetch_done_out, bus.lsu_done_out}, 0);
    check("rst_data", bus.ifetch_data_out | bus.lsu_rdata_out, 0);
    @(posedge clk);
    #1;

    // Word fetch at 0x100: addresses in cycles 1..4, enable through 5, done in 6.
    do_fetch(32'h100, t0);
    for (int k = 0; k < 4; k++) check("fetch_addr", log_a[t0+1+k], 32'h100 + 32'(k));
    for (int k = 1; k <= 5; k++) check("fetch_en", log_en[t0+k], 1);
    check("fetch_en_off", log_en[t0+6], 0);
    check("fetch_done_c5", log_ifd[t0+5], 0);
    check("fetch_done_c6", log_ifd[t0+6], 1);

    // Half store wrapping past the top of RAM.
    do_lsu(1'b1, 2'b01, 32'h0001_FFFF, 32'h0000_BEEF, t0);
    check("st_a1", log_a[t0+1], 32'h1FFFF);
    check("st_d1", log_d[t0+1], 32'hEF);
    check("st_rnw1", log_rnw[t0+1], 0);
    check("st_a2", log_a[t0+2], 32'h0);
    check("st_d2", log_d[t0+2], 32'hBE);
    check("st_rnw2", log_rnw[t0+2], 0);
    check("st_done_c3", log_lsd[t0+3], 1);
    check("st_en_c3", log_en[t0+3], 0);
    check("st_rnw_c3", log_rnw[t0+3], 1);
    check("ram_1ffff", mem[17'h1FFFF], 32'hEF);
    check("ram_00000", mem[0], 32'hBE);
    do_lsu(1'b0, 2'b00, 32'h0, 32'h0, t0);
    check("ld_byte_done_c3", log_lsd[t0+3], 1);

    // Both requesting from reset: LSU first, fetch granted in LSU's done cycle.
    do_reset();
    fork
      do_fetch(32'h100, t1);
      do_lsu(1'b0, 2'b11, 32'h40, 32'h0, t0);
    join
    check("both_lsu_first", log_a[t0+1], 32'h40);
    check("both_lsu_done", log_lsd[t0+6], 1);
    check("both_if_addr", log_a[t0+7], 32'h100);
    check("both_if_en", log_en[t0+7], 1);
    check("both_if_done", log_ifd[t0+12], 1);

    // Fetch flushed in cycle 3 with an LSU load waiting.
    fork
      begin
        bus.ifetch_addr_in = 32'h200;
        bus.ifetch_req_in  = 1'b1;
        t1 = cyc;
        repeat (3) @(posedge clk);
        #1;
        bus.ifetch_clr_in = 1'b1;
        bus.ifetch_req_in = 1'b0;
        @(posedge clk);
        #1 bus.ifetch_clr_in = 1'b0;
      end
      begin
        @(posedge clk);
        #1 do_lsu(1'b0, 2'b00, 32'h0001_FFFF, 32'h0, t0);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("abort_en_c3", log_en[t1+3], 1);
    check("abort_en_c4", log_en[t1+4], 0);
    check("abort_lsu_addr", log_a[t1+5], 32'h1FFFF);
    check("abort_lsu_en", log_en[t1+5], 1);
    check("abort_no_done", count_ifd(t1, t1 + 10), 0);

    // Flush on the last capture cycle suppresses done.
    bus.ifetch_addr_in = 32'h104;
    bus.ifetch_req_in  = 1'b1;
    t1 = cyc;
    repeat (5) @(posedge clk);
    #1;
    bus.ifetch_clr_in = 1'b1;
    bus.ifetch_req_in = 1'b0;
    @(posedge clk);
    #1 bus.ifetch_clr_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("lastcap_en_c5", log_en[t1+5], 1);
    check("lastcap_en_c6", log_en[t1+6], 0);
    check("lastcap_no_done", count_ifd(t1, t1 + 9), 0);

    // Word store/load round trip, then the 2'b10 length as a word.
    do_lsu(1'b1, 2'b11, 32'h20, 32'hDEAD_BEEF, t0);
    do_lsu(1'b0, 2'b11, 32'h20, 32'h0, t0);
    check("ld_word_done_c6", log_lsd[t0+6], 1);
    do_lsu(1'b0, 2'b10, 32'h20, 32'h0, t0);

    // Mixed traffic over edge and truncated addresses.
    for (int i = 0; i < 10; i++) begin
      do_lsu(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             addr_tab[$urandom_range(0, 5)], $urandom, t0);
      if (i % 3 == 0) do_fetch(addr_tab[$urandom_range(0, 5)], t1);
    end

    // Reset in the middle of a word store.
    bus.lsu_we_in    = 1'b1;
    bus.lsu_len_in   = 2'b11;
    bus.lsu_addr_in  = 32'h300;
    bus.lsu_wdata_in = 32'h1234_5678;
    bus.lsu_req_in   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_en", bus.ram_en_out, 0);
    check("midrst_rnw", bus.ram_r_nw_out, 1);
    check("midrst_a", bus.ram_a_out, 0);
    check("midrst_d", bus.ram_d_out, 0);
    check("midrst_done", bus.lsu_done_out, 0);
    check("midrst_rdata", bus.lsu_rdata_out, 0);
    idle_inputs();
    sb_lsu.delete();
    sb_if.delete();
    exp_last = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    t1 = cyc;
    repeat (6) @(posedge clk);
    #1;
    begin
      int en_cnt = 0, dn_cnt = 0;
      for (int i = t1; i < t1 + 6; i++) begin
        en_cnt += int'(log_en[i]);
        dn_cnt += int'(log_lsd[i]) + int'(log_ifd[i]);
      end
      check("postrst_idle_en", en_cnt, 0);
      check("postrst_no_done", dn_cnt, 0);
    end

    check("sb_if_empty", sb_if.size(), 0);
    check("sb_lsu_empty", sb_lsu.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
